// File: rtl/dispatch_unit.sv
// dispatch_unit: in-order dual-issue dispatch stage.
// Decoded instructions queue in a FIFO. Up to two per cycle leave the head in program order.
// Each one takes a reservation station and has its sources renamed through a four-entry register
// status table. Result broadcasts free stations and clear table entries.
module dispatch_unit #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid1,
   input  logic        in_valid2,
   input  logic [31:0] in_inst1,
   input  logic [31:0] in_inst2,
   output logic        in_ready,
   input  logic [39:0] addbus,
   input  logic [39:0] multbus,
   input  logic [39:0] loadbus,
   input  logic [7:0]  st_done,
   output logic [39:0] instbus1,
   output logic [39:0] instbus2,
   output logic [3:0]  fifo_cnt
);

   localparam int PW = $clog2(DEPTH);

   // Station index -> tag. Indices 0-2 are adders, 3-4 multipliers, 5-6 loads, 7-8 stores.
   localparam logic [8:0][7:0] TAGS = {8'h51, 8'h50, 8'h41, 8'h40, 8'h31, 8'h30,
                                       8'h22, 8'h21, 8'h20};

   // The set of stations an opcode may use. Opcodes outside 01-04 have no stations.
   function automatic logic [8:0] class_mask(input logic [7:0] op);
      case (op)
         8'h01:   class_mask = 9'b001100000;
         8'h02:   class_mask = 9'b110000000;
         8'h03:   class_mask = 9'b000000111;
         8'h04:   class_mask = 9'b000011000;
         default: class_mask = 9'b000000000;
      endcase
   endfunction

   function automatic logic [8:0] lowest(input logic [8:0] v);
      lowest = v & (~v + 9'd1);
   endfunction

   function automatic logic [7:0] onehot_tag(input logic [8:0] oh);
      onehot_tag = 8'h0;
      for (int i = 0; i < 9; i++) if (oh[i]) onehot_tag = TAGS[i];
   endfunction

   function automatic logic [8:0] tag_onehot(input logic [7:0] t);
      for (int i = 0; i < 9; i++) tag_onehot[i] = (t == TAGS[i]);
   endfunction

   function automatic logic writes_dest(input logic [7:0] op);
      writes_dest = (op == 8'h01) || (op == 8'h03) || (op == 8'h04);
   endfunction

   function automatic logic uses_src2(input logic [7:0] op);
      uses_src2 = (op == 8'h02) || (op == 8'h03) || (op == 8'h04);
   endfunction

   // A pending tag that is being broadcast right now would be missed by the consumer,
   // so the architectural register code is emitted instead.
   function automatic logic [7:0] rename(input logic [7:0] src, input logic [7:0] st,
                                         input logic [31:0] btags);
      logic hit;
      hit = (st == btags[31:24]) || (st == btags[23:16]) ||
            (st == btags[15:8])  || (st == btags[7:0]);
      rename = ((st == 8'h0) || hit) ? src : st;
   endfunction

   logic [31:0]       mem_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [8:0]        busy_q, busy_d;
   logic [3:0][7:0]   status_q, status_d;
   logic [39:0]       bus1_q, bus1_d, bus2_q, bus2_d;

   logic [31:0]       head0, head1, btags;
   logic [8:0]        free0, free1, grant0, grant1, clr_mask;
   logic [7:0]        tag0, tag1, s1_0, s2_0, s1_1, s2_1;
   logic              disp0, disp1, inv0, inv1;
   logic [1:0]        push_n, pop_n;
   logic              unused_bits;

   assign unused_bits = ^{addbus[31:0], multbus[31:0], loadbus[31:0]};
   assign in_ready    = (cnt_q <= (PW+1)'(DEPTH - 2));
   assign fifo_cnt    = 4'(cnt_q);
   assign instbus1    = bus1_q;
   assign instbus2    = bus2_q;

   // Head selection, station allocation, renaming and all next-state values.
   always_comb begin
      btags  = {addbus[39:32], multbus[39:32], loadbus[39:32], st_done};
      head0  = mem_q[rd_ptr_q];
      head1  = mem_q[rd_ptr_q + PW'(1)];

      // Allocation only sees stations free at the start of the cycle.
      free0  = class_mask(head0[31:24]) & ~busy_q;
      grant0 = lowest(free0);
      tag0   = onehot_tag(grant0);
      inv0   = (cnt_q != '0) && (class_mask(head0[31:24]) == 9'b0);
      disp0  = (cnt_q != '0) && (free0 != 9'b0);

      free1  = class_mask(head1[31:24]) & ~busy_q & ~grant0;
      grant1 = lowest(free1);
      tag1   = onehot_tag(grant1);
      inv1   = disp0 && (cnt_q >= (PW+1)'(2)) && (class_mask(head1[31:24]) == 9'b0);
      disp1  = disp0 && (cnt_q >= (PW+1)'(2)) && (free1 != 9'b0);

      if (inv0)                 pop_n = 2'd1;
      else if (disp1 || inv1)   pop_n = 2'd2;
      else if (disp0)           pop_n = 2'd1;
      else                      pop_n = 2'd0;

      push_n = 2'd0;
      if (in_ready && in_valid1) push_n = in_valid2 ? 2'd2 : 2'd1;

      s1_0 = rename(head0[23:16], status_q[head0[17:16]], btags);
      s2_0 = uses_src2(head0[31:24]) ? rename(head0[15:8], status_q[head0[9:8]], btags)
                                     : head0[15:8];
      s1_1 = rename(head1[23:16], status_q[head1[17:16]], btags);
      s2_1 = uses_src2(head1[31:24]) ? rename(head1[15:8], status_q[head1[9:8]], btags)
                                     : head1[15:8];
      // The younger instruction reads the older one's result from its new station.
      if (writes_dest(head0[31:24]) && (head1[23:16] == head0[7:0])) s1_1 = tag0;
      if (writes_dest(head0[31:24]) && uses_src2(head1[31:24]) && (head1[15:8] == head0[7:0]))
         s2_1 = tag0;

      bus1_d = disp0 ? {tag0, head0[31:24], s1_0, s2_0, head0[7:0]} : 40'h0;
      bus2_d = disp1 ? {tag1, head1[31:24], s1_1, s2_1, head1[7:0]} : 40'h0;

      // Tags of stations that are already free are ignored.
      clr_mask = (tag_onehot(btags[31:24]) | tag_onehot(btags[23:16]) |
                  tag_onehot(btags[15:8])  | tag_onehot(btags[7:0])) & busy_q;
      busy_d   = (busy_q & ~clr_mask) | (disp0 ? grant0 : 9'b0) | (disp1 ? grant1 : 9'b0);

      // Clears first, then the dispatch writes, so writes win and head1 wins over head0.
      for (int r = 0; r < 4; r++)
         status_d[r] = ((tag_onehot(status_q[r]) & clr_mask) != 9'b0) ? 8'h0 : status_q[r];
      if (disp0 && writes_dest(head0[31:24])) status_d[head0[1:0]] = tag0;
      if (disp1 && writes_dest(head1[31:24])) status_d[head1[1:0]] = tag1;

      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      cnt_d    = cnt_q + (PW+1)'(push_n) - (PW+1)'(pop_n);
   end

   // Control state, status table and registered instruction buses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
         status_q <= '0;
         bus1_q   <= '0;
         bus2_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         status_q <= status_d;
         bus1_q   <= bus1_d;
         bus2_q   <= bus2_d;
      end
   end

   // FIFO storage; contents are meaningless outside the occupied window, so no reset.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) mem_q[wr_ptr_q] <= in_inst1;
      if (push_n == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= in_inst2;
   end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit. Expected bus words are computed by hand from the
// instruction encodings and the station allocation order.
module tb_dispatch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid1, in_valid2;
   logic [31:0] in_inst1, in_inst2;
   logic        in_ready;
   logic [39:0] addbus, multbus, loadbus;
   logic [7:0]  st_done;
   logic [39:0] instbus1, instbus2;
   logic [3:0]  fifo_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] A = 32'h03101112;

   dispatch_unit #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid1(in_valid1), .in_valid2(in_valid2),
      .in_inst1(in_inst1), .in_inst2(in_inst2), .in_ready(in_ready),
      .addbus(addbus), .multbus(multbus), .loadbus(loadbus), .st_done(st_done),
      .instbus1(instbus1), .instbus2(instbus2), .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic push1(input logic [31:0] a);
      in_valid1 = 1'b1; in_inst1 = a;
      step();
      in_valid1 = 1'b0; in_inst1 = '0;
   endtask

   task automatic push2(input logic [31:0] a, input logic [31:0] b);
      in_valid1 = 1'b1; in_valid2 = 1'b1; in_inst1 = a; in_inst2 = b;
      step();
      in_valid1 = 1'b0; in_valid2 = 1'b0; in_inst1 = '0; in_inst2 = '0;
   endtask

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_buses(input string tag, input logic [39:0] e1, input logic [39:0] e2);
      check({tag, " bus1"}, instbus1, e1);
      check({tag, " bus2"}, instbus2, e2);
   endtask

   initial begin
      rst = 1'b1; in_valid1 = 1'b0; in_valid2 = 1'b0; in_inst1 = '0; in_inst2 = '0;
      addbus = '0; multbus = '0; loadbus = '0; st_done = '0;

      // Reset state
      step();
      rst = 1'b0;
      check_buses("reset", 40'h0, 40'h0);
      check("reset in_ready", 40'(in_ready), 40'h1);
      check("reset fifo_cnt", 40'(fifo_cnt), 40'h0);

      // Dispatch pair with head1 picking up head0's new tag
      push2(32'h03111213, 32'h03131011);
      check("pair cnt after push", 40'(fifo_cnt), 40'h2);
      check_buses("pair idle", 40'h0, 40'h0);
      step();
      check_buses("pair", 40'h2003111213, 40'h2103201011);
      check("pair cnt", 40'(fifo_cnt), 40'h0);
      check("pair R3", 40'(dut.status_q[3]), 40'h20);
      check("pair R1", 40'(dut.status_q[1]), 40'h21);
      addbus = {8'h20, 32'h0};
      step();
      addbus = '0;
      check("bcast R3 clr", 40'(dut.status_q[3]), 40'h0);
      check("bcast R1 kept", 40'(dut.status_q[1]), 40'h21);

      // Adder exhaustion
      do_reset();
      push2(32'h03101112, 32'h03101113);
      push2(32'h03101110, 32'h03101111);
      check_buses("exh first", 40'h2003101112, 40'h2103101113);
      check("exh cnt", 40'(fifo_cnt), 40'h2);
      step();
      check_buses("exh third", 40'h2203101110, 40'h0);
      step();
      check_buses("exh stall", 40'h0, 40'h0);
      addbus = {8'h21, 32'h0};
      step();
      addbus = '0;
      check_buses("exh free cycle", 40'h0, 40'h0);
      check("exh R3 clr", 40'(dut.status_q[3]), 40'h0);
      step();
      check_buses("exh fourth", 40'h2103221111, 40'h0);
      check("exh R1", 40'(dut.status_q[1]), 40'h21);
      check("exh cnt end", 40'(fifo_cnt), 40'h0);

      // Broadcast race on a renamed source
      do_reset();
      push1(32'h04101112);
      step();
      check_buses("race mult", 40'h3004101112, 40'h0);
      check("race R2 set", 40'(dut.status_q[2]), 40'h30);
      push1(32'h03121210);
      multbus = {8'h30, 32'h0};
      step();
      multbus = '0;
      check_buses("race add", 40'h2003121210, 40'h0);
      check("race R2 clr", 40'(dut.status_q[2]), 40'h0);
      check("race R0", 40'(dut.status_q[0]), 40'h20);

      // Blocked head holds back a dispatchable ADD
      do_reset();
      push2(32'h04101112, 32'h04101111);
      push2(32'h04101110, 32'h03101111);
      check_buses("blk first", 40'h3004101112, 40'h3104101111);
      step();
      check_buses("blk stall1", 40'h0, 40'h0);
      step();
      check_buses("blk stall2", 40'h0, 40'h0);
      multbus = {8'h30, 32'h0};
      step();
      check_buses("blk free cycle", 40'h0, 40'h0);
      check("blk cnt", 40'(fifo_cnt), 40'h2);
      multbus = {8'h31, 32'h0};
      step();
      multbus = '0;
      check_buses("blk release", 40'h3004101110, 40'h2003301111);
      check("blk R1 write beats clr", 40'(dut.status_q[1]), 40'h20);
      check("blk R0", 40'(dut.status_q[0]), 40'h30);

      // LOAD and STORE stations; STORE leaves the table alone
      do_reset();
      push2(32'h01101112, 32'h02121013);
      step();
      check_buses("ldst", 40'h4001101112, 40'h5002401013);
      check("ldst R2", 40'(dut.status_q[2]), 40'h40);
      check("ldst R3", 40'(dut.status_q[3]), 40'h0);

      // Invalid opcode is dropped
      do_reset();
      push2(32'h05101112, A);
      step();
      check_buses("inv drop", 40'h0, 40'h0);
      check("inv cnt", 40'(fifo_cnt), 40'h1);
      step();
      check_buses("inv next", 40'h2003101112, 40'h0);

      // Full FIFO, dropped push, then reset mid-operation
      do_reset();
      push2(A, A);
      push2(A, A);
      check("full R2 head1 wins", 40'(dut.status_q[2]), 40'h21);
      push2(A, A);
      check("full cnt3", 40'(fifo_cnt), 40'h3);
      push1(A);
      push2(A, A);
      push2(A, A);
      check("full cnt8", 40'(fifo_cnt), 40'h8);
      check("full in_ready", 40'(in_ready), 40'h0);
      push2(A, A);
      check("full drop cnt", 40'(fifo_cnt), 40'h8);
      do_reset();
      check("rst cnt", 40'(fifo_cnt), 40'h0);
      check("rst in_ready", 40'(in_ready), 40'h1);
      check_buses("rst", 40'h0, 40'h0);
      check("rst status", 40'(dut.status_q), 40'h0);
      push1(A);
      step();
      check_buses("rst redispatch", 40'h2003101112, 40'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
